road_signal_renderer: RTL and testbench

Pixel-colour stage placed directly downstream of the VGA timing decoder. It consumes the decoder's pixel coordinates, display-enable and sync outputs, plus its 1-in-4 pixel strobe. It runs a frame-paced traffic-light state machine and paints a road scene with a three-lamp signal head. It drives 12-bit RGB and pipeline-aligned sync signals to the VGA connector.

---
 rtl/road_signal_renderer_if.sv | 25 ++
 rtl/road_signal_renderer.sv | 200 ++++++++++++++++++++
 tb/tb_road_signal_renderer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/road_signal_renderer_if.sv
// Pixel bus between the VGA timing decoder and the road signal renderer:
// coordinates, enable, syncs and pixel strobe in; colour and aligned syncs out.
interface road_signal_renderer_if;
  logic       pclk;
  logic [9:0] x_pixel;
  logic [9:0] y_pixel;
  logic       DE;
  logic       h_sync;
  logic       v_sync;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       h_sync_o;
  logic       v_sync_o;

  modport master (
    output pclk, x_pixel, y_pixel, DE, h_sync, v_sync,
    input  red, green, blue, h_sync_o, v_sync_o
  );

  modport slave (
    input  pclk, x_pixel, y_pixel, DE, h_sync, v_sync,
    output red, green, blue, h_sync_o, v_sync_o
  );
endinterface

// File: rtl/road_signal_renderer.sv
// Frame-paced traffic-light FSM and two-stage road-scene colour pipeline,
// driving 12-bit RGB with syncs delayed to stay aligned with the colour.
module road_signal_renderer #(
  parameter int GREEN_FRAMES  = 300,
  parameter int YELLOW_FRAMES = 120,
  parameter int RED_FRAMES    = 300,
  parameter int MIN_GREEN     = 60,
  parameter int LAMP_X        = 560,
  parameter int LAMP_Y        = 40,
  parameter int LAMP_SIZE     = 32,
  parameter int LAMP_GAP      = 8,
  parameter int ROAD_Y0       = 300,
  parameter int ROAD_Y1       = 420
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ped_req,
  road_signal_renderer_if.slave       vga,
  output logic [1:0]                  light_state
);

  typedef enum logic [1:0] {
    ST_RED    = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } light_t;

  localparam logic [9:0] RED_LAST    = 10'(RED_FRAMES - 1);
  localparam logic [9:0] GREEN_LAST  = 10'(GREEN_FRAMES - 1);
  localparam logic [9:0] YELLOW_LAST = 10'(YELLOW_FRAMES - 1);
  localparam logic [9:0] MIN_LAST    = 10'(MIN_GREEN - 1);

  localparam int STEP = LAMP_SIZE + LAMP_GAP;
  localparam int MID  = (ROAD_Y0 + ROAD_Y1) / 2;

  localparam logic [10:0] LX0 = 11'(LAMP_X);
  localparam logic [10:0] LX1 = 11'(LAMP_X + LAMP_SIZE);
  localparam logic [10:0] RY0 = 11'(LAMP_Y);
  localparam logic [10:0] RY1 = 11'(LAMP_Y + LAMP_SIZE);
  localparam logic [10:0] YY0 = 11'(LAMP_Y + STEP);
  localparam logic [10:0] YY1 = 11'(LAMP_Y + STEP + LAMP_SIZE);
  localparam logic [10:0] GY0 = 11'(LAMP_Y + 2 * STEP);
  localparam logic [10:0] GY1 = 11'(LAMP_Y + 2 * STEP + LAMP_SIZE);
  localparam logic [10:0] HX0 = 11'(LAMP_X - 4);
  localparam logic [10:0] HX1 = 11'(LAMP_X + LAMP_SIZE + 4);
  localparam logic [10:0] HY0 = 11'(LAMP_Y - 4);
  localparam logic [10:0] HY1 = 11'(LAMP_Y + 3 * LAMP_SIZE + 2 * LAMP_GAP + 4);
  localparam logic [10:0] DY0 = 11'(MID - 2);
  localparam logic [10:0] DY1 = 11'(MID + 2);
  localparam logic [10:0] ROAD_LO = 11'(ROAD_Y0);
  localparam logic [10:0] ROAD_HI = 11'(ROAD_Y1);

  light_t      state;
  logic [9:0]  fcnt;
  logic        prev_vs;
  logic        vs_seen_high;
  logic        ped_lat;
  logic        tick;
  logic        go_yellow;

  logic [10:0] x_ext;
  logic [10:0] y_ext;
  logic        in_lamp_x;
  logic [2:0]  lamp_hit;
  logic        housing_hit;
  logic        dash_hit;
  logic        road_hit;

  logic [2:0]  s1_lamp;
  logic        s1_housing;
  logic        s1_dash;
  logic        s1_road;
  logic        s1_de;
  logic        s1_hs;
  logic        s1_vs;

  logic [11:0] colour;
  logic [11:0] rgb;
  logic        hs_out;
  logic        vs_out;

  // A v_sync already low at reset release must not count as a frame start,
  // so a tick also needs v_sync to have been sampled high since reset.
  assign tick      = vga.pclk & vs_seen_high & prev_vs & ~vga.v_sync;
  assign go_yellow = tick && (state == ST_GREEN) &&
                     ((fcnt == GREEN_LAST) || (ped_lat && (fcnt >= MIN_LAST)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_RED;
      fcnt         <= '0;
      prev_vs      <= 1'b1;
      vs_seen_high <= 1'b0;
    end else if (vga.pclk) begin
      prev_vs <= vga.v_sync;
      if (vga.v_sync) vs_seen_high <= 1'b1;
      if (tick) begin
        case (state)
          ST_RED: begin
            if (fcnt == RED_LAST) begin
              state <= ST_GREEN;
              fcnt  <= '0;
            end else begin
              fcnt <= fcnt + 10'd1;
            end
          end
          ST_GREEN: begin
            if (go_yellow) begin
              state <= ST_YELLOW;
              fcnt  <= '0;
            end else begin
              fcnt <= fcnt + 10'd1;
            end
          end
          ST_YELLOW: begin
            if (fcnt == YELLOW_LAST) begin
              state <= ST_RED;
              fcnt  <= '0;
            end else begin
              fcnt <= fcnt + 10'd1;
            end
          end
          default: begin
            state <= ST_RED;
            fcnt  <= '0;
          end
        endcase
      end
    end
  end

  // The request latch runs every clk so short pulses between strobes are kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ped_lat <= 1'b0;
    end else if (go_yellow) begin
      ped_lat <= 1'b0;
    end else if (ped_req) begin
      ped_lat <= 1'b1;
    end
  end

  assign light_state = state;

  assign x_ext       = {1'b0, vga.x_pixel};
  assign y_ext       = {1'b0, vga.y_pixel};
  assign in_lamp_x   = (x_ext >= LX0) && (x_ext < LX1);
  assign lamp_hit[0] = in_lamp_x && (y_ext >= RY0) && (y_ext < RY1);
  assign lamp_hit[1] = in_lamp_x && (y_ext >= YY0) && (y_ext < YY1);
  assign lamp_hit[2] = in_lamp_x && (y_ext >= GY0) && (y_ext < GY1);
  assign housing_hit = (x_ext >= HX0) && (x_ext < HX1) && (y_ext >= HY0) && (y_ext < HY1);
  assign dash_hit    = (y_ext >= DY0) && (y_ext < DY1) && !vga.x_pixel[5];
  assign road_hit    = (y_ext >= ROAD_LO) && (y_ext < ROAD_HI);

  always_comb begin
    colour = 12'h282;
    if (!s1_de)               colour = 12'h000;
    else if (s1_lamp[0])      colour = (state == ST_RED)    ? 12'hF00 : 12'h300;
    else if (s1_lamp[1])      colour = (state == ST_YELLOW) ? 12'hFF0 : 12'h330;
    else if (s1_lamp[2])      colour = (state == ST_GREEN)  ? 12'h0F0 : 12'h030;
    else if (s1_housing)      colour = 12'h111;
    else if (s1_dash)         colour = 12'hFFF;
    else if (s1_road)         colour = 12'h666;
  end

  // S2 reads the live FSM state; a state change at the tick therefore
  // first shows on the pixel sampled at that same tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_lamp    <= '0;
      s1_housing <= 1'b0;
      s1_dash    <= 1'b0;
      s1_road    <= 1'b0;
      s1_de      <= 1'b0;
      s1_hs      <= 1'b1;
      s1_vs      <= 1'b1;
      rgb        <= '0;
      hs_out     <= 1'b1;
      vs_out     <= 1'b1;
    end else if (vga.pclk) begin
      s1_lamp    <= lamp_hit;
      s1_housing <= housing_hit;
      s1_dash    <= dash_hit;
      s1_road    <= road_hit;
      s1_de      <= vga.DE;
      s1_hs      <= vga.h_sync;
      s1_vs      <= vga.v_sync;
      rgb        <= colour;
      hs_out     <= s1_hs;
      vs_out     <= s1_vs;
    end
  end

  assign vga.red      = rgb[11:8];
  assign vga.green    = rgb[7:4];
  assign vga.blue     = rgb[3:0];
  assign vga.h_sync_o = hs_out;
  assign vga.v_sync_o = vs_out;

endmodule

// File: tb/tb_road_signal_renderer.sv
// Directed bench for road_signal_renderer: reset, colour/latency table,
// light sequencing, pedestrian cut and mid-operation reset.
module tb_road_signal_renderer;

  logic       clk = 1'b0;
  logic       reset;
  logic       pclk;
  logic [9:0] xp;
  logic [9:0] yp;
  logic       de;
  logic       hs;
  logic       vs;
  logic       ped_req;
  logic [1:0] light_a;
  logic [1:0] light_b;

  int tests = 0;
  int failures = 0;

  always #5 clk = ~clk;

  road_signal_renderer_if bus_a ();
  road_signal_renderer_if bus_b ();

  assign bus_a.pclk = pclk;
  assign bus_a.x_pixel = xp;
  assign bus_a.y_pixel = yp;
  assign bus_a.DE = de;
  assign bus_a.h_sync = hs;
  assign bus_a.v_sync = vs;
  assign bus_b.pclk = pclk;
  assign bus_b.x_pixel = xp;
  assign bus_b.y_pixel = yp;
  assign bus_b.DE = de;
  assign bus_b.h_sync = hs;
  assign bus_b.v_sync = vs;

  road_signal_renderer #(
    .GREEN_FRAMES(3), .YELLOW_FRAMES(2), .RED_FRAMES(4), .MIN_GREEN(1)
  ) dut_a (
    .clk(clk), .reset(reset), .ped_req(ped_req), .vga(bus_a), .light_state(light_a)
  );

  road_signal_renderer #(
    .GREEN_FRAMES(10), .YELLOW_FRAMES(2), .RED_FRAMES(4), .MIN_GREEN(2)
  ) dut_b (
    .clk(clk), .reset(reset), .ped_req(ped_req), .vga(bus_b), .light_state(light_b)
  );

  // Colour table, default lamp geometry, light in RED.
  logic [9:0]  tab_x   [17] = '{10'd570, 10'd570, 10'd10,  10'd570, 10'd557, 10'd555,
                                10'd570, 10'd0,   10'd32,  10'd100, 10'd100, 10'd100,
                                10'd570, 10'd591, 10'd592, 10'd64,  10'd64};
  logic [9:0]  tab_y   [17] = '{10'd50,  10'd130, 10'd10,  10'd90,  10'd50,  10'd50,
                                10'd75,  10'd360, 10'd360, 10'd300, 10'd420, 10'd419,
                                10'd50,  10'd71,  10'd71,  10'd358, 10'd362};
  logic        tab_de  [17] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic        tab_hs  [17] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [15:0] tab_rgb [17] = '{16'hF00, 16'h030, 16'h282, 16'h330, 16'h111, 16'h282,
                                16'h111, 16'hFFF, 16'h666, 16'h666, 16'h282, 16'h666,
                                16'h000, 16'hF00, 16'h111, 16'hFFF, 16'h666};

  // Light state after each of 12 ticks with RED=4, GREEN=3, YELLOW=2.
  logic [1:0]  seq_exp [12] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1,
                                2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};

  function automatic logic [15:0] rgb_a();
    return {4'h0, bus_a.red, bus_a.green, bus_a.blue};
  endfunction

  function automatic logic [15:0] rgb_b();
    return {4'h0, bus_b.red, bus_b.green, bus_b.blue};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    tests++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One pixel-strobe period: inputs sampled on the single pclk clk edge.
  task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y,
                               input logic d, input logic h, input logic v);
    @(negedge clk);
    xp = x; yp = y; de = d; hs = h; vs = v;
    pclk = 1'b1;
    @(negedge clk);
    pclk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame();
    applyStimulus(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic expect_frames(input int n, input logic [1:0] exp_state,
                               input logic use_b, input string tag);
    for (int i = 0; i < n; i++) begin
      run_frame();
      checkOutput(tag, {14'b0, (use_b ? light_b : light_a)}, {14'b0, exp_state});
    end
  endtask

  task automatic pulse_ped();
    @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    pclk = 1'b0; xp = '0; yp = '0; de = 1'b0; hs = 1'b1; vs = 1'b1; ped_req = 1'b0;

    // Reset held with random inputs: outputs pinned to their idle values.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      xp = 10'($urandom); yp = 10'($urandom);
      de = 1'($urandom_range(0, 1)); hs = 1'($urandom_range(0, 1));
      vs = 1'($urandom_range(0, 1)); pclk = 1'($urandom_range(0, 1));
      ped_req = 1'($urandom_range(0, 1));
      #2;
      checkOutput("reset_rgb", rgb_a(), 16'h000);
      checkOutput("reset_hs_o", {15'b0, bus_a.h_sync_o}, 16'h1);
      checkOutput("reset_vs_o", {15'b0, bus_a.v_sync_o}, 16'h1);
      checkOutput("reset_light_a", {14'b0, light_a}, 16'h0);
      checkOutput("reset_light_b", {14'b0, light_b}, 16'h0);
    end
    @(negedge clk);
    pclk = 1'b0; de = 1'b0; hs = 1'b1; vs = 1'b1; ped_req = 1'b0;
    reset = 1'b1;

    // Colour and two-stage latency: output after pixel i reflects pixel i-1.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(tab_x[i], tab_y[i], tab_de[i], tab_hs[i], 1'b1);
      if (i > 0) begin
        checkOutput("table_rgb", rgb_a(), tab_rgb[i-1]);
        checkOutput("table_hs_o", {15'b0, bus_a.h_sync_o}, {15'b0, tab_hs[i-1]});
      end
    end
    applyStimulus(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("table_rgb_last", rgb_a(), tab_rgb[16]);

    // Sequencing on dut_a: state only moves on the v_sync falling-edge strobe.
    do_reset();
    begin
      logic [1:0] prev_state;
      prev_state = 2'd0;
      for (int i = 0; i < 12; i++) begin
        applyStimulus(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("seq_hold", {14'b0, light_a}, {14'b0, prev_state});
        if (i > 0) checkOutput("seq_vs_o_low", {15'b0, bus_a.v_sync_o}, 16'h0);
        applyStimulus(10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("seq_tick", {14'b0, light_a}, {14'b0, seq_exp[i]});
        checkOutput("seq_vs_o_high", {15'b0, bus_a.v_sync_o}, 16'h1);
        prev_state = seq_exp[i];
      end
    end

    // Pedestrian cut on dut_b (GREEN=10, MIN_GREEN=2).
    do_reset();
    expect_frames(3, 2'd0, 1'b1, "ped_red");
    expect_frames(1, 2'd1, 1'b1, "ped_to_green");
    pulse_ped();
    applyStimulus(10'd570, 10'd130, 1'b1, 1'b1, 1'b1);
    applyStimulus(10'd570, 10'd50, 1'b1, 1'b1, 1'b1);
    checkOutput("green_lamp_lit", rgb_b(), 16'h0F0);
    applyStimulus(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("red_lamp_unlit", rgb_b(), 16'h300);
    expect_frames(1, 2'd1, 1'b1, "ped_green_min");
    expect_frames(1, 2'd2, 1'b1, "ped_cut_yellow");
    applyStimulus(10'd570, 10'd90, 1'b1, 1'b1, 1'b1);
    applyStimulus(10'd570, 10'd130, 1'b1, 1'b1, 1'b1);
    checkOutput("yellow_lamp_lit", rgb_b(), 16'hFF0);
    applyStimulus(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("green_lamp_unlit", rgb_b(), 16'h030);
    expect_frames(1, 2'd2, 1'b1, "ped_yellow");
    expect_frames(1, 2'd0, 1'b1, "ped_back_red");
    pulse_ped();
    expect_frames(3, 2'd0, 1'b1, "ped_held_red");
    expect_frames(1, 2'd1, 1'b1, "ped_held_green");
    expect_frames(1, 2'd1, 1'b1, "ped_held_green_min");
    expect_frames(1, 2'd2, 1'b1, "ped_held_cut");
    expect_frames(1, 2'd2, 1'b1, "ped_yellow2");
    expect_frames(4, 2'd0, 1'b1, "ped_red2");
    expect_frames(1, 2'd1, 1'b1, "ped_green_full_start");
    expect_frames(9, 2'd1, 1'b1, "ped_green_full");
    expect_frames(1, 2'd2, 1'b1, "ped_green_full_end");

    // Mid-operation reset on dut_a while in YELLOW at fcnt=1.
    do_reset();
    expect_frames(3, 2'd0, 1'b0, "mid_red");
    expect_frames(3, 2'd1, 1'b0, "mid_green");
    expect_frames(2, 2'd2, 1'b0, "mid_yellow");
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_reset_light", {14'b0, light_a}, 16'h0);
    checkOutput("mid_reset_rgb", rgb_a(), 16'h000);
    vs = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    applyStimulus(10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("low_vs_no_tick", {14'b0, light_a}, 16'h0);
    expect_frames(3, 2'd0, 1'b0, "post_reset_red");
    expect_frames(1, 2'd1, 1'b0, "post_reset_green");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
